// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: format codes, opcode constants and the B/J decoder bias
package instruction_encoder_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [32:0] BJ_BIAS  = 33'd4;
endpackage

// File: rtl/instruction_encoder_imm_pack.sv
// instruction_encoder_imm_pack: places immediate (and funct7) bits into the instruction word and range-checks them
//   in: i_fmt, i_opcode, i_funct3, i_funct7, i_imm   out: o_bits (opcode/reg/funct3 fields zero), o_legal
module instruction_encoder_imm_pack
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_bits,
  output logic        o_legal
);
  logic signed [32:0] w_imm_s;
  logic signed [32:0] w_fs;
  logic [32:0]        w_fu;
  logic               w_shift;
  logic               w_sltiu;
  logic               w_s12;
  // the decoder subtracts 4 from B/J offsets, so the encoded field is imm+4; 33 bits keep the carry
  assign w_imm_s = {i_imm[31], i_imm};
  assign w_fs    = w_imm_s + BJ_BIAS;
  // BLTU/BGEU immediates arrive zero-extended, so their sum is taken unsigned
  assign w_fu    = {1'b0, i_imm} + BJ_BIAS;
  assign w_shift = i_opcode == OP_IMM && (i_funct3 == 3'b001 || i_funct3 == 3'b101);
  assign w_sltiu = i_opcode == OP_IMM && i_funct3 == 3'b011;
  assign w_s12   = w_imm_s >= -33'sd2048 && w_imm_s <= 33'sd2047;
  always_comb begin
    o_bits  = '0;
    o_legal = 1'b0;
    case (i_fmt)
      FMT_R: begin
        o_bits  = {i_funct7, 25'b0};
        o_legal = 1'b1;
      end
      FMT_I: begin
        o_bits  = w_shift ? {i_funct7, i_imm[4:0], 20'b0} : {i_imm[11:0], 20'b0};
        o_legal = w_shift ? i_imm < 32'd32 : w_sltiu ? i_imm < 32'd4096 : w_s12;
      end
      FMT_S: begin
        o_bits  = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_legal = w_s12;
      end
      FMT_B: begin
        o_bits  = {w_fs[12], w_fs[10:5], 13'b0, w_fs[4:1], w_fs[11], 7'b0};
        o_legal = !w_fs[0] && (i_funct3[2:1] == 2'b11 ? w_fu <= 33'd8190
                                                       : w_fs >= -33'sd4096 && w_fs <= 33'sd4094);
      end
      FMT_U: begin
        o_bits  = {i_imm[31:12], 12'b0};
        o_legal = i_imm[11:0] == 12'b0;
      end
      FMT_J: begin
        o_bits  = {w_fs[20], w_fs[10:1], w_fs[11], w_fs[19:12], 12'b0};
        o_legal = !w_fs[0] && w_fs >= -33'sd1048576 && w_fs <= 33'sd1048575;
      end
      default: begin
        o_bits  = '0;
        o_legal = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32I fields into instruction words streamed with sequential addresses
//   in: clk, rst_n, start/start_addr, in_valid + field bundle, out_ready
//   out: in_ready, out_valid/out_instr/out_addr, err_pulse, err_flag
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_pulse,
  output logic                  err_flag
);
  logic [31:0]           w_bits;
  logic                  w_legal;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_rd;
  logic                  w_rs1;
  logic                  w_rs2;
  logic                  w_f3;
  logic [31:0]           w_instr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [31:0]           r_out_instr;
  logic                  r_out_valid;
  logic                  r_err_pulse;
  logic                  r_err_flag;
  instruction_encoder_imm_pack u_imm_pack (
    .i_fmt   (fmt),
    .i_opcode(opcode),
    .i_funct3(funct3),
    .i_funct7(funct7),
    .i_imm   (imm),
    .o_bits  (w_bits),
    .o_legal (w_legal)
  );
  assign in_ready = !start && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && w_legal;
  assign w_rd     = fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J;
  assign w_rs1    = fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B;
  assign w_rs2    = fmt == FMT_R || fmt == FMT_S || fmt == FMT_B;
  assign w_f3     = w_rs1;
  assign w_instr  = w_bits | {7'b0, w_rs2 ? rs2 : 5'b0, w_rs1 ? rs1 : 5'b0,
                              w_f3 ? funct3 : 3'b0, w_rd ? rd : 5'b0, opcode};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= {BASE_ADDR[ADDR_WIDTH-1:2], 2'b00};
      r_out_addr  <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_flag  <= 1'b0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      r_out_valid <= w_load ? 1'b1 : out_ready ? 1'b0 : r_out_valid;
      if (start) begin
        r_addr     <= {start_addr[ADDR_WIDTH-1:2], 2'b00};
        r_err_flag <= 1'b0;
      end else if (w_load) begin
        r_out_instr <= w_instr;
        r_out_addr  <= r_addr;
        r_addr      <= r_addr + ADDR_WIDTH'(4);
      end else if (w_accept) begin
        r_err_flag <= 1'b1;
      end
    end
  end
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign err_pulse = r_err_pulse;
  assign err_flag  = r_err_flag;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed vectors with a scoreboard queue checked by an output monitor
module tb_instruction_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic        err_flag;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;
  exp_t        exp_q[$];
  int          err_exp = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_addr = 32'h0;
  instruction_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_pulse(err_pulse), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word got=%h@%h want=none", out_instr, out_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_addr !== e.addr) begin
            bad++;
            $display("FAIL word got=%h@%h want=%h@%h", out_instr, out_addr, e.instr, e.addr);
          end
        end
      end
      if (err_pulse) begin
        total++;
        if (err_exp == 0) begin
          bad++;
          $display("FAIL unexpected_err_pulse got=1 want=0");
        end else err_exp--;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic ok,
                      input logic [31:0] ei);
    int n = 0;
    @(negedge clk);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready0 want=in_ready1");
      in_valid = 1'b0;
      return;
    end
    if (ok) begin
      exp_q.push_back('{instr: ei, addr: m_addr});
      m_addr += 32'd4;
    end else err_exp++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4, 1'b1, 32'h0020_8463);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b110, 7'd0, 32'hFFFF_FFF8, 1'b0, 32'h0);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2044, 1'b1, 32'h0010_00EF);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 1'b0, 32'h0);
    chk("err_flag_after_odd_jal", 32'(err_flag), 32'd1);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 1'b0, 32'h0);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b011, 7'd0, 32'd4095, 1'b1, 32'hFFF0_3093);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0, 32'h0);
    send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    send(3'd1, 7'b0010011, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h0050_8113);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, 32'h0020_81B3);
      chk("stall_addr", out_addr, m_addr - 32'd4);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
    @(negedge clk);
    chk("err_flag_before_start", 32'(err_flag), 32'd1);
    start = 1'b1;
    start_addr = 32'h103;
    fmt = 3'd1; opcode = 7'b0010011; rd = 5'd1; rs1 = 5'd1; funct3 = 3'b001; imm = 32'd3;
    in_valid = 1'b1;
    #1 chk("start_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    in_valid = 1'b0;
    chk("start_clears_err_flag", 32'(err_flag), 32'd0);
    m_addr = 32'h100;
    send(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3, 1'b1, 32'h0030_9093);
    @(negedge clk);
    start = 1'b1;
    start_addr = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 start = 1'b0;
    m_addr = 32'hFFFF_FFFC;
    send(3'd1, 7'b0010011, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h0050_8113);
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_exp != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("err_pulses_seen", 32'(err_exp), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
